// File: rtl/cpu_pkg.sv
// Shared datapath constants for the single-cycle CPU: data/address widths,
// named architectural register indices and small register-index helpers.
package cpu_pkg;

   localparam int unsigned DATA_W     = 32;
   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned REG_DEPTH  = 2 ** REG_ADDR_W;

   // Named architectural registers (MIPS-style conventions)
   localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
   localparam logic [REG_ADDR_W-1:0] REG_AT   = 5'd1;
   localparam logic [REG_ADDR_W-1:0] REG_V0   = 5'd2;
   localparam logic [REG_ADDR_W-1:0] REG_V1   = 5'd3;
   localparam logic [REG_ADDR_W-1:0] REG_A0   = 5'd4;
   localparam logic [REG_ADDR_W-1:0] REG_T0   = 5'd8;
   localparam logic [REG_ADDR_W-1:0] REG_S0   = 5'd16;
   localparam logic [REG_ADDR_W-1:0] REG_GP   = 5'd28;
   localparam logic [REG_ADDR_W-1:0] REG_SP   = 5'd29;
   localparam logic [REG_ADDR_W-1:0] REG_FP   = 5'd30;
   localparam logic [REG_ADDR_W-1:0] REG_RA   = 5'd31;

   // Read-port forwarding mode
   typedef enum logic {
      BYPASS_OFF = 1'b0,
      BYPASS_ON  = 1'b1
   } bypass_mode_e;

   // True when the register index names the hardwired-zero register
   function automatic logic is_zero_reg(input logic [REG_ADDR_W-1:0] addr);
      return (addr == REG_ZERO);
   endfunction

endpackage

// File: rtl/reg_read_port.sv
// One asynchronous register-file read port: selects the addressed entry,
// forces register 0 to zero and optionally forwards the in-flight write data.
module reg_read_port
   import cpu_pkg::*;
#(
   parameter int unsigned DATA_W = cpu_pkg::DATA_W,
   parameter int unsigned ADDR_W = cpu_pkg::REG_ADDR_W,
   parameter int unsigned BYPASS = 1
) (
   input  logic [ADDR_W-1:0]                      i_addr,
   input  logic [(2**ADDR_W)-1:0][DATA_W-1:0]     i_regs,
   input  logic                                   i_wr_en,
   input  logic [ADDR_W-1:0]                      i_wr_addr,
   input  logic [DATA_W-1:0]                      i_wr_data,
   output logic [DATA_W-1:0]                      o_data
);

   logic              w_addr_zero;
   logic              w_bypass_hit;
   logic [DATA_W-1:0] w_stored;

   // Decode: stored value of the addressed entry and the forwarding condition
   always_comb begin
      w_addr_zero  = (i_addr == '0);
      w_stored     = i_regs[i_addr];
      w_bypass_hit = (BYPASS != 0) && i_wr_en && (i_wr_addr != '0)
                     && (i_wr_addr == i_addr);
   end

   // Output mux: forwarded write data wins, then zero-forcing, then storage
   always_comb begin
      o_data = '0;
      if (w_bypass_hit) begin
         o_data = i_wr_data;
      end else if (w_addr_zero) begin
         o_data = '0;
      end else begin
         o_data = w_stored;
      end
   end

endmodule

// File: rtl/reg_file.sv
// 32-entry general-purpose register file: two asynchronous read ports
// (rs, rt), one synchronous write port, register 0 hardwired to zero.
module reg_file
   import cpu_pkg::*;
#(
   parameter int unsigned DATA_W = cpu_pkg::DATA_W,
   parameter int unsigned ADDR_W = cpu_pkg::REG_ADDR_W,
   parameter int unsigned BYPASS = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] rs_addr,
   input  logic [ADDR_W-1:0] rt_addr,
   output logic [DATA_W-1:0] rd_data1,
   output logic [DATA_W-1:0] rd_data2,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   // r0 has no storage; only r1..r(DEPTH-1) are flops
   logic [DATA_W-1:0]             r_regs [1:DEPTH-1];
   logic [DEPTH-1:0][DATA_W-1:0]  w_regs;
   logic                          w_wr_commit;

   // A write commits only when enabled and not aimed at the zero register
   always_comb begin
      w_wr_commit = wr_en && (wr_addr != '0);
   end

   // Storage: asynchronous clear of all entries, then one write per edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 1; i < DEPTH; i++) begin
            r_regs[i] <= '0;
         end
      end else begin
         for (int unsigned i = 1; i < DEPTH; i++) begin
            if (w_wr_commit && (wr_addr == ADDR_W'(i))) begin
               r_regs[i] <= wr_data;
            end
         end
      end
   end

   // Present the storage as a flat vector for the read ports; entry 0 is zero
   always_comb begin
      w_regs[0] = '0;
      for (int unsigned i = 1; i < DEPTH; i++) begin
         w_regs[i] = r_regs[i];
      end
   end

   reg_read_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .BYPASS (BYPASS)
   ) u_rs_port (
      .i_addr    (rs_addr),
      .i_regs    (w_regs),
      .i_wr_en   (wr_en),
      .i_wr_addr (wr_addr),
      .i_wr_data (wr_data),
      .o_data    (rd_data1)
   );

   reg_read_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .BYPASS (BYPASS)
   ) u_rt_port (
      .i_addr    (rt_addr),
      .i_regs    (w_regs),
      .i_wr_en   (wr_en),
      .i_wr_addr (wr_addr),
      .i_wr_data (wr_data),
      .o_data    (rd_data2)
   );

endmodule
